// File: rtl/mac_addr_gen.sv
// Two-level strided address generator with valid/ready output and line/transfer markers.
// Optional alignment check enabled by defining MAC_ADDR_GEN_ALIGN_CHECK_EN.
module mac_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] word_stride_i,
    input  logic [ADDR_WIDTH-1:0] line_stride_i,
    input  logic [CNT_WIDTH-1:0]  line_len_i,
    input  logic [CNT_WIDTH-1:0]  nb_lines_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  addr_valid_o,
    input  logic                  addr_ready_i,
    output logic                  line_last_o,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
    logic [ADDR_WIDTH-1:0] word_stride_q, word_stride_d;
    logic [ADDR_WIDTH-1:0] line_stride_q, line_stride_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0]  line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0]  line_len_q, line_len_d;
    logic [CNT_WIDTH-1:0]  nb_lines_q, nb_lines_d;
    logic                  err_q, err_d;
    logic                  cfg_err;
    logic                  line_end;
    logic                  xfer_end;

`ifdef MAC_ADDR_GEN_ALIGN_CHECK_EN
    assign cfg_err = |{base_addr_i[1:0], word_stride_i[1:0], line_stride_i[1:0]};
`else
    assign cfg_err = 1'b0;
`endif

    assign line_end = (word_cnt_q == line_len_q - CNT_WIDTH'(1));
    assign xfer_end = line_end && (line_cnt_q == nb_lines_q - CNT_WIDTH'(1));

    assign addr_o       = addr_q;
    assign addr_valid_o = (state_q == RUN);
    assign line_last_o  = (state_q == RUN) && line_end;
    assign last_o       = (state_q == RUN) && xfer_end;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign err_o        = (state_q == DONE) && err_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        line_base_d   = line_base_q;
        word_stride_d = word_stride_q;
        line_stride_d = line_stride_q;
        word_cnt_d    = word_cnt_q;
        line_cnt_d    = line_cnt_q;
        line_len_d    = line_len_q;
        nb_lines_d    = nb_lines_q;
        err_d         = err_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d        = base_addr_i;
                    line_base_d   = base_addr_i;
                    word_stride_d = word_stride_i;
                    line_stride_d = line_stride_i;
                    line_len_d    = line_len_i;
                    nb_lines_d    = nb_lines_i;
                    word_cnt_d    = '0;
                    line_cnt_d    = '0;
                    err_d         = cfg_err;
                    if (cfg_err || line_len_i == '0 || nb_lines_i == '0) state_d = DONE;
                    else                                                  state_d = RUN;
                end
            end
            RUN: begin
                if (addr_ready_i) begin
                    if (!line_end) begin
                        word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
                        addr_d     = addr_q + word_stride_q;
                    end else if (!xfer_end) begin
                        word_cnt_d  = '0;
                        line_cnt_d  = line_cnt_q + CNT_WIDTH'(1);
                        line_base_d = line_base_q + line_stride_q;
                        addr_d      = line_base_q + line_stride_q;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // clear overrides start and any pending handshake
        if (clear_i) begin
            state_d = IDLE;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            line_base_q   <= '0;
            word_stride_q <= '0;
            line_stride_q <= '0;
            word_cnt_q    <= '0;
            line_cnt_q    <= '0;
            line_len_q    <= '0;
            nb_lines_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            line_base_q   <= line_base_d;
            word_stride_q <= word_stride_d;
            line_stride_q <= line_stride_d;
            word_cnt_q    <= word_cnt_d;
            line_cnt_q    <= line_cnt_d;
            line_len_q    <= line_len_d;
            nb_lines_q    <= nb_lines_d;
            err_q         <= err_d;
        end
    end

endmodule
